// File: rtl/usb_tx_cache.sv
// usb_tx_cache: ping-pong transmit buffer feeding the CY7C68013 slave-FIFO
// interface. Acquisition words fill one of two packet banks. A completed
// bank is announced with a one-cycle tx_cache_sop and then served over the
// registered tx_cache_addr/tx_cache_data read port. The bank is freed once
// the last address has been read.
//
// Ports:
//   ifclk          interface clock (single domain)
//   rst            synchronous reset, active high
//   wr_vd/wr_data  one sample word per cycle
//   tx_cache_sop   one-cycle pulse, a full bank is ready to send
//   tx_cache_addr  read address from the USB interface
//   tx_cache_data  read data, registered, one-cycle latency
//   bank_full      per-bank full flags
//   ovf_cnt        saturating count of dropped words
module usb_tx_cache #(
  parameter int DATA_NBIT = 16,
  parameter int ADDR_NBIT = 8,
  parameter int OVF_NBIT  = 16
) (
  input  logic                 ifclk,
  input  logic                 rst,
  input  logic                 wr_vd,
  input  logic [DATA_NBIT-1:0] wr_data,
  output logic                 tx_cache_sop,
  input  logic [ADDR_NBIT-1:0] tx_cache_addr,
  output logic [DATA_NBIT-1:0] tx_cache_data,
  output logic [1:0]           bank_full,
  output logic [OVF_NBIT-1:0]  ovf_cnt
);

  typedef enum logic [1:0] {
    R_IDLE,
    R_SOP,
    R_DRAIN
  } rd_state_t;

  rd_state_t state;

  logic [DATA_NBIT-1:0] mem [2**(ADDR_NBIT+1)];

  logic [ADDR_NBIT-1:0] wr_ptr;
  logic                 fill_bank;
  logic                 rd_bank;
  logic                 wr_en;
  logic                 bank_done;
  logic                 release_bank;

  // Flags are sampled before this cycle's update, so a write arriving in the
  // release cycle of its target bank is still dropped.
  always_comb begin
    wr_en        = wr_vd && !bank_full[fill_bank];
    bank_done    = wr_en && (wr_ptr == '1);
    release_bank = (state == R_DRAIN) && (tx_cache_addr == '1);
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge ifclk) begin
    if (wr_en) begin
      mem[{fill_bank, wr_ptr}] <= wr_data;
    end
  end

  always_ff @(posedge ifclk) begin
    if (rst) begin
      tx_cache_data <= '0;
    end else begin
      tx_cache_data <= mem[{rd_bank, tx_cache_addr}];
    end
  end

  // Write pointer, fill bank and overflow counter.
  always_ff @(posedge ifclk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill_bank <= 1'b0;
      ovf_cnt   <= '0;
    end else if (wr_vd) begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (bank_done) begin
          fill_bank <= ~fill_bank;
        end
      end else if (ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  // Set and clear always target different banks: a bank under release is
  // full, so the writer cannot be filling it in that cycle.
  always_ff @(posedge ifclk) begin
    if (rst) begin
      bank_full <= '0;
    end else begin
      if (bank_done) begin
        bank_full[fill_bank] <= 1'b1;
      end
      if (release_bank) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  // Read sequencer: announce a full bank, then hold it until the consumer
  // reads the last address. Stalled addresses keep it in R_DRAIN.
  always_ff @(posedge ifclk) begin
    if (rst) begin
      state        <= R_IDLE;
      tx_cache_sop <= 1'b0;
      rd_bank      <= 1'b0;
    end else begin
      tx_cache_sop <= 1'b0;
      case (state)
        R_IDLE: begin
          if (bank_full[rd_bank]) begin
            state        <= R_SOP;
            tx_cache_sop <= 1'b1;
          end
        end
        R_SOP: begin
          state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (release_bank) begin
            rd_bank <= ~rd_bank;
            state   <= R_IDLE;
          end
        end
        default: begin
          state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_cache.sv
module tb_usb_tx_cache;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int OW    = 16;
  localparam int DEPTH = 256;

  logic          ifclk = 1'b0;
  logic          rst;
  logic          wr_vd;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] tx_cache_addr;
  logic          tx_cache_sop;
  logic [DW-1:0] tx_cache_data;
  logic [1:0]    bank_full;
  logic [OW-1:0] ovf_cnt;

  int total = 0;
  int bad = 0;
  int sop_seen = 0;

  usb_tx_cache #(
    .DATA_NBIT(DW),
    .ADDR_NBIT(AW),
    .OVF_NBIT (OW)
  ) dut (
    .ifclk        (ifclk),
    .rst          (rst),
    .wr_vd        (wr_vd),
    .wr_data      (wr_data),
    .tx_cache_sop (tx_cache_sop),
    .tx_cache_addr(tx_cache_addr),
    .tx_cache_data(tx_cache_data),
    .bank_full    (bank_full),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 ifclk = ~ifclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two banks, a writer and a reader that owns one bank
  // from its announcement until the last address is read.
  logic [DW-1:0] mm [0:2*DEPTH-1];
  int            m_ptr, m_fill, m_rd, m_ovf;
  bit [1:0]      m_full, nf;
  bit            m_owned, m_sop, m_init, m_dv, rel, was_sop;
  logic [DW-1:0] m_data;

  always @(posedge ifclk) begin
    if (rst) begin
      m_ptr = 0; m_fill = 0; m_rd = 0; m_ovf = 0; m_full = 2'b00;
      m_owned = 0; m_sop = 0; m_data = '0; m_dv = 1; m_init = 1;
    end else begin
      m_dv   = m_full[m_rd];
      m_data = mm[m_rd*DEPTH + int'(tx_cache_addr)];
      nf = m_full;
      rel = 0;
      was_sop = m_sop;
      m_sop = 0;
      if (m_owned) begin
        if (!was_sop && int'(tx_cache_addr) == DEPTH-1) begin
          nf[m_rd] = 0;
          rel = 1;
          m_owned = 0;
        end
      end else if (m_full[m_rd]) begin
        m_owned = 1;
        m_sop = 1;
      end
      if (wr_vd) begin
        if (!m_full[m_fill]) begin
          mm[m_fill*DEPTH + m_ptr] = wr_data;
          if (m_ptr == DEPTH-1) begin
            nf[m_fill] = 1;
            m_fill ^= 1;
            m_ptr = 0;
          end else begin
            m_ptr++;
          end
        end else if (m_ovf < (1 << OW) - 1) begin
          m_ovf++;
        end
      end
      if (rel) m_rd ^= 1;
      m_full = nf;
    end
  end

  always @(negedge ifclk) begin
    if (m_init) begin
      chk("sop", 32'(tx_cache_sop), 32'(m_sop));
      chk("bank_full", 32'(bank_full), 32'(m_full));
      chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
      if (m_dv) chk("data", 32'(tx_cache_data), 32'(m_data));
      if (tx_cache_sop === 1'b1) sop_seen++;
    end
  end

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_vd = 1'b0; tx_cache_addr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_vd = 1'b1;
      wr_data = DW'(base + i);
      tick();
    end
    wr_vd = 1'b0;
  endtask

  task automatic wait_sop(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_cache_sop === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic drain(input int from);
    for (int a = from; a < DEPTH; a++) begin
      tx_cache_addr = AW'(a);
      tick();
    end
    tx_cache_addr = '0;
  endtask

  int sop_before;

  initial begin
    rst = 1'b1; wr_vd = 1'b0; wr_data = '0; tx_cache_addr = '0;

    // Reset state
    do_reset();
    chk("rst_sop", 32'(tx_cache_sop), 32'd0);
    chk("rst_full", 32'(bank_full), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_data", 32'(tx_cache_data), 32'd0);

    // Single bank fill and drain, latency N+1 / N+2
    write_words(0, DEPTH);
    chk("t1_full_n1", 32'(bank_full), 32'h1);
    chk("t1_sop_n1", 32'(tx_cache_sop), 32'd0);
    tick();
    chk("t1_sop_n2", 32'(tx_cache_sop), 32'd1);
    tick();
    chk("t1_sop_n3", 32'(tx_cache_sop), 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      tx_cache_addr = AW'(a);
      tick();
      chk("t1_data", 32'(tx_cache_data), 32'(a));
    end
    tx_cache_addr = '0;
    chk("t1_full_rel", 32'(bank_full), 32'd0);
    sop_before = sop_seen;
    repeat (10) tick();
    chk("t1_no_sop", 32'(sop_seen - sop_before), 32'd0);

    // Stall mid-drain
    do_reset();
    write_words(16'h1000, DEPTH);
    wait_sop("stall_sop");
    tick();
    for (int a = 0; a <= 100; a++) begin
      tx_cache_addr = AW'(a);
      tick();
    end
    sop_before = sop_seen;
    repeat (50) begin
      tick();
      chk("stall_data", 32'(tx_cache_data), 32'h1064);
      chk("stall_full", 32'(bank_full), 32'h1);
    end
    chk("stall_no_sop", 32'(sop_seen - sop_before), 32'd0);
    for (int a = 101; a < DEPTH; a++) begin
      chk("stall_full_resume", 32'(bank_full), 32'h1);
      tx_cache_addr = AW'(a);
      tick();
    end
    tx_cache_addr = '0;
    chk("stall_full_rel", 32'(bank_full), 32'd0);

    // Bank 1 completes in the release cycle of bank 0
    do_reset();
    write_words(16'h2000, DEPTH);
    wait_sop("sim_sop0");
    tx_cache_addr = '0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      tx_cache_addr = AW'(i);
      wr_vd = 1'b1;
      wr_data = DW'(16'h3000 + i);
      tick();
    end
    wr_vd = 1'b0;
    tx_cache_addr = '0;
    chk("sim_full", 32'(bank_full), 32'h2);
    chk("sim_sop_r", 32'(tx_cache_sop), 32'd0);
    tick();
    chk("sim_sop_r1", 32'(tx_cache_sop), 32'd1);
    tick();
    drain(0);
    chk("sim_full_end", 32'(bank_full), 32'd0);

    // Ping-pong streaming
    do_reset();
    sop_before = sop_seen;
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          write_words(b * DEPTH, DEPTH);
          repeat (8) tick();
        end
      end
      begin
        for (int p = 0; p < 4; p++) begin
          wait_sop("stream_sop");
          tick();
          drain(0);
        end
      end
    join
    chk("stream_sops", 32'(sop_seen - sop_before), 32'd4);
    chk("stream_ovf", 32'(ovf_cnt), 32'd0);
    chk("stream_full", 32'(bank_full), 32'd0);

    // Overflow with no draining
    do_reset();
    write_words(0, 600);
    chk("ovf_full", 32'(bank_full), 32'h3);
    chk("ovf_cnt88", 32'(ovf_cnt), 32'd88);
    drain(0);
    chk("ovf_full_rel0", 32'(bank_full), 32'h2);
    write_words(16'hABCD, 1);
    wait_sop("ovf_sop1");
    tick();
    drain(0);
    write_words(16'hABCE, DEPTH - 1);
    wait_sop("ovf_sop0");
    tx_cache_addr = '0;
    tick();
    tx_cache_addr = '0;
    tick();
    chk("ovf_marker", 32'(tx_cache_data), 32'hABCD);
    drain(1);
    chk("ovf_full_end", 32'(bank_full), 32'd0);
    chk("ovf_cnt_hold", 32'(ovf_cnt), 32'd88);

    // Reset mid-drain with both banks full
    do_reset();
    write_words(16'h4000, 2 * DEPTH + 8);
    chk("rd_full", 32'(bank_full), 32'h3);
    chk("rd_ovf", 32'(ovf_cnt), 32'd8);
    for (int a = 0; a <= 50; a++) begin
      tx_cache_addr = AW'(a);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("rd_sop", 32'(tx_cache_sop), 32'd0);
    chk("rd_full0", 32'(bank_full), 32'd0);
    chk("rd_ovf0", 32'(ovf_cnt), 32'd0);
    chk("rd_data0", 32'(tx_cache_data), 32'd0);
    rst = 1'b0;
    tx_cache_addr = '0;
    sop_before = sop_seen;
    repeat (5) tick();
    chk("rd_no_sop", 32'(sop_seen - sop_before), 32'd0);
    write_words(16'h5000, DEPTH);
    chk("rd_fill_full", 32'(bank_full), 32'h1);
    chk("rd_fill_sop_n1", 32'(tx_cache_sop), 32'd0);
    tick();
    chk("rd_fill_sop_n2", 32'(tx_cache_sop), 32'd1);
    tick();
    drain(0);
    chk("rd_fill_end", 32'(bank_full), 32'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
